// File: rtl/wb_macro_mux.sv
// Wishbone window decoder, bus-timeout and pad/irq ownership fabric for up to 8 user macros.
// Latency: CSR/error ack in cycle 2, macro ack one cycle after m_ack_i; aborts on cyc drop, no stall beyond that.
module wb_macro_mux #(
  parameter int          N_MACROS  = 2,
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int          SLOT_BITS = 16,
  parameter int          TIMEOUT   = 255,
  parameter int          IO_W      = 38
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic [N_MACROS-1:0]      m_cyc_o,
  output logic [N_MACROS-1:0]      m_stb_o,
  output logic                     m_we_o,
  output logic [3:0]               m_sel_o,
  output logic [31:0]              m_adr_o,
  output logic [31:0]              m_dat_o,
  input  logic [N_MACROS-1:0]      m_ack_i,
  input  logic [32*N_MACROS-1:0]   m_dat_i,
  input  logic [IO_W*N_MACROS-1:0] m_io_out_i,
  input  logic [IO_W*N_MACROS-1:0] m_io_oeb_i,
  output logic [IO_W-1:0]          io_out,
  output logic [IO_W-1:0]          io_oeb,
  input  logic [3*N_MACROS-1:0]    m_irq_i,
  output logic [2:0]               user_irq
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [31:0] WIN_MASK = (32'd1 << SLOT_BITS) - 32'd1;
  localparam logic [31:0] CSR_ID   = {16'h4D50, 8'(N_MACROS), 8'(SLOT_BITS)};

  typedef enum logic [2:0] {IDLE, FWD, CSR, ERR, ACK} state_t;

  state_t              state;
  logic [2:0]          slot;
  logic [15:0]         tmo_ctr;
  logic [15:0]         timeout_cnt;
  logic [2:0]          io_owner;
  logic [N_MACROS-1:0] irq_en;

  logic [31:0]         dec_off;
  logic [31:0]         dec_slot;
  logic                dec_mac;
  logic                dec_csr;
  logic [N_MACROS-1:0] dec_onehot;
  logic                sel_ack;
  logic [31:0]         sel_dat;
  logic [31:0]         csr_off;
  logic                csr_in_win;
  logic                csr_wr;
  logic [31:0]         csr_rdata;

  // Subtraction wraps addresses below the base into a huge slot, so they decode as errors.
  assign dec_off  = wbs_adr_i - ADDR_BASE;
  assign dec_slot = dec_off >> SLOT_BITS;
  assign dec_mac  = dec_slot < 32'(N_MACROS);
  assign dec_csr  = dec_slot == 32'(N_MACROS);

  always_comb begin
    dec_onehot = '0;
    sel_ack    = 1'b0;
    sel_dat    = '0;
    for (int k = 0; k < N_MACROS; k++) begin
      dec_onehot[k] = (dec_slot == 32'(k));
      if (slot == 3'(k)) begin
        sel_ack = m_ack_i[k];
        sel_dat = m_dat_i[32*k +: 32];
      end
    end
  end

  assign csr_off    = m_adr_o - ADDR_BASE;
  assign csr_in_win = (csr_off & WIN_MASK) < 32'h10;
  assign csr_wr     = m_we_o && csr_in_win && m_sel_o[0];

  always_comb begin
    csr_rdata = '0;
    if (csr_in_win) begin
      case (m_adr_o[3:2])
        2'd0: csr_rdata = {29'd0, io_owner};
        2'd1: csr_rdata = 32'(irq_en);
        2'd2: csr_rdata = {16'd0, timeout_cnt};
        2'd3: csr_rdata = CSR_ID;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      slot        <= '0;
      tmo_ctr     <= '0;
      timeout_cnt <= '0;
      io_owner    <= '0;
      irq_en      <= '1;
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= '0;
      m_cyc_o     <= '0;
      m_stb_o     <= '0;
      m_we_o      <= 1'b0;
      m_sel_o     <= '0;
      m_adr_o     <= '0;
      m_dat_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            m_adr_o <= wbs_adr_i;
            m_dat_o <= wbs_dat_i;
            m_we_o  <= wbs_we_i;
            m_sel_o <= wbs_sel_i;
            slot    <= dec_slot[2:0];
            tmo_ctr <= '0;
            if (dec_mac) begin
              m_cyc_o <= dec_onehot;
              m_stb_o <= dec_onehot;
              state   <= FWD;
            end else if (dec_csr) begin
              state <= CSR;
            end else begin
              state <= ERR;
            end
          end
        end
        FWD: begin
          if (!wbs_cyc_i) begin
            m_cyc_o <= '0;
            m_stb_o <= '0;
            state   <= IDLE;
          end else if (sel_ack) begin
            // Ack is checked first so a same-cycle ack beats the timeout.
            wbs_dat_o <= sel_dat;
            wbs_ack_o <= 1'b1;
            m_cyc_o   <= '0;
            m_stb_o   <= '0;
            state     <= ACK;
          end else if (tmo_ctr == TMO_LAST) begin
            wbs_dat_o <= 32'hBAD0_0000 | {29'd0, slot};
            wbs_ack_o <= 1'b1;
            m_cyc_o   <= '0;
            m_stb_o   <= '0;
            if (timeout_cnt != 16'hFFFF)
              timeout_cnt <= timeout_cnt + 16'd1;
            state <= ACK;
          end else begin
            tmo_ctr <= tmo_ctr + 16'd1;
          end
        end
        CSR: begin
          if (!wbs_cyc_i) begin
            state <= IDLE;
          end else begin
            wbs_dat_o <= csr_rdata;
            wbs_ack_o <= 1'b1;
            state     <= ACK;
            if (csr_wr) begin
              case (m_adr_o[3:2])
                2'd0: io_owner    <= m_dat_o[2:0];
                2'd1: irq_en      <= m_dat_o[N_MACROS-1:0];
                2'd2: timeout_cnt <= '0;
                default: ;
              endcase
            end
          end
        end
        ERR: begin
          if (!wbs_cyc_i) begin
            state <= IDLE;
          end else begin
            wbs_dat_o <= 32'hBADA_DD00;
            wbs_ack_o <= 1'b1;
            state     <= ACK;
          end
        end
        ACK: begin
          wbs_ack_o <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // An out-of-range owner releases the pads to inputs.
  always_comb begin
    io_out = '0;
    io_oeb = '1;
    for (int k = 0; k < N_MACROS; k++) begin
      if (io_owner == 3'(k)) begin
        io_out = m_io_out_i[IO_W*k +: IO_W];
        io_oeb = m_io_oeb_i[IO_W*k +: IO_W];
      end
    end
  end

  always_comb begin
    user_irq = '0;
    for (int k = 0; k < N_MACROS; k++)
      user_irq = user_irq | (m_irq_i[3*k +: 3] & {3{irq_en[k]}});
  end

endmodule
